// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the multi-channel tick generator.
// Holds the channel state encoding, mode constants and the default divisor helper.
package tick_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Clamped to 1 so a zero divisor can never reach a channel.
    function automatic int unsigned default_div(input int unsigned clk_freq,
                                                input int unsigned target_freq);
        if (target_freq == 0 || clk_freq < target_freq) begin
            return 1;
        end
        return clk_freq / target_freq;
    endfunction

endpackage

// File: rtl/multi_tick_generator_if.sv
// Configuration write port of the tick generator: valid/ready handshake plus reject pulse.
interface multi_tick_generator_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 32
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_mode;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_mode,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_mode,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/tick_channel.sv
// One tick-enable channel: IDLE/RUN FSM, period counter, shadow and active divisor.
// Shadow settings reach the active period only at start or at a wrap edge.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned DEFAULT_DIV = 1,
    parameter bit          AUTO_START  = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             advance,
    input  logic             start,
    input  logic             stop,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             busy,
    output logic             tick_enable
);

    localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
    localparam ch_state_e        RESET_ST = AUTO_START ? ST_RUN : ST_IDLE;

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             act_mode_q, act_mode_d;
    logic             sh_mode_q, sh_mode_d;
    logic             at_top;

    assign at_top      = (cnt_q == act_div_q - DIV_W'(1));
    assign busy        = (state_q == ST_RUN);
    assign tick_enable = busy && at_top && advance;

    always_comb begin
        sh_div_d   = wr_en ? wr_div  : sh_div_q;
        sh_mode_d  = wr_en ? wr_mode : sh_mode_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        act_mode_d = act_mode_q;

        if (wr_en && state_q == ST_IDLE) begin
            act_div_d  = wr_div;
            act_mode_d = wr_mode;
        end

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d    = ST_RUN;
            cnt_d      = '0;
            act_div_d  = sh_div_d;
            act_mode_d = sh_mode_d;
        end else if (state_q == ST_RUN && advance) begin
            if (at_top) begin
                // A write landing on the wrap edge already governs the next period.
                cnt_d      = '0;
                act_div_d  = sh_div_d;
                act_mode_d = sh_mode_d;
                if (act_mode_q == MODE_ONESHOT) begin
                    state_d = ST_IDLE;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= RESET_ST;
            cnt_q      <= '0;
            act_div_q  <= DEF_DIV;
            sh_div_q   <= DEF_DIV;
            act_mode_q <= MODE_CONT;
            sh_mode_q  <= MODE_CONT;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            sh_div_q   <= sh_div_d;
            act_mode_q <= act_mode_d;
            sh_mode_q  <= sh_mode_d;
        end
    end

endmodule

// File: rtl/multi_tick_generator.sv
// NUM_CH independent tick-enable channels with run-time divisors and a shared config port.
// Define TICK_PRESCALE_EN to slow every channel by a shared free-running PRESCALE strobe.
module multi_tick_generator
    import tick_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned TARGET_FREQ = 2,
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned AUTO_START  = 0,
    parameter int unsigned PRESCALE    = 1000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    multi_tick_generator_if.slave cfg,
    input  logic [NUM_CH-1:0]     start,
    input  logic [NUM_CH-1:0]     stop,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     tick_enable
);

    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DEFAULT_DIV = default_div(CLK_FREQ, TARGET_FREQ);

    logic              ready_q, err_q;
    logic              wr_fire, cfg_bad;
    logic [NUM_CH-1:0] wr_sel;
    logic              strobe;

    assign wr_fire       = cfg.cfg_valid && ready_q;
    assign cfg_bad       = (cfg.cfg_div == '0) || (32'(cfg.cfg_ch) >= NUM_CH);
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = wr_fire && !cfg_bad && (cfg.cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            err_q   <= wr_fire && cfg_bad;
        end
    end

`ifdef TICK_PRESCALE_EN
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_q;

    // Free-running from reset; channel starts do not realign the phase.
    assign strobe = (pre_q == PRE_W'(PRESCALE - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= strobe ? '0 : pre_q + PRE_W'(1);
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE;
    assign strobe          = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .AUTO_START  (AUTO_START != 0)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .advance     (strobe),
            .start       (start[i]),
            .stop        (stop[i]),
            .wr_en       (wr_sel[i]),
            .wr_div      (cfg.cfg_div),
            .wr_mode     (cfg.cfg_mode),
            .busy        (busy[i]),
            .tick_enable (tick_enable[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Self-checking bench: directed tick-timing scenarios plus random config/start/stop traffic,
// compared every cycle against a countdown model of each channel.
module tb_multi_tick_generator;
    import tick_gen_pkg::*;

    localparam int unsigned NCH  = 3;
    localparam int unsigned DW   = 8;
    localparam int          DEF  = 6;   // 24 Hz clock / 4 Hz target
`ifdef TICK_PRESCALE_EN
    localparam int          P    = 4;
`else
    localparam int          P    = 1;
`endif

    logic           sys_clk   = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic [NCH-1:0] start     = '0;
    logic [NCH-1:0] stop      = '0;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] tick_enable;

    multi_tick_generator_if #(.NUM_CH(NCH), .DIV_W(DW)) cfg_if ();

    multi_tick_generator #(
        .NUM_CH      (NCH),
        .CLK_FREQ    (24),
        .TARGET_FREQ (4),
        .DIV_W       (DW),
        .AUTO_START  (0),
        .PRESCALE    (4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cfg         (cfg_if),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .tick_enable (tick_enable)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo_excl,
                               input int hi_incl);
        checks++;
        if (act <= lo_excl || act > hi_incl) begin
            errors++;
            $display("FAIL %s: got %0d, expected in (%0d,%0d]", name, act, lo_excl, hi_incl);
        end
    endtask

    // Model: each running channel counts down the strobes left before its next tick.
    bit m_run     [NCH] = '{default: 1'b0};
    int m_left    [NCH] = '{default: 0};
    int m_sh_div  [NCH] = '{default: DEF};
    bit m_sh_mode [NCH] = '{default: 1'b0};
    bit m_mode    [NCH] = '{default: 1'b0};
    int m_pre   = 0;
    bit m_ready = 1'b0;
    bit m_err   = 1'b0;

    function automatic bit m_tick(input int i);
        return m_run[i] && m_left[i] == 0 && m_pre == P - 1;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        bit stb, bad, wr_ok, tk;
        if (!sys_rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_run[i] = 1'b0; m_left[i] = 0; m_sh_div[i] = DEF;
                m_sh_mode[i] = 1'b0; m_mode[i] = 1'b0;
            end
            m_pre = 0; m_ready = 1'b0; m_err = 1'b0;
        end else begin
            stb   = (m_pre == P - 1);
            bad   = (cfg_if.cfg_div == 0) || (cfg_if.cfg_ch >= NCH);
            wr_ok = cfg_if.cfg_valid && m_ready && !bad;
            for (int i = 0; i < NCH; i++) begin
                tk = m_tick(i);
                if (wr_ok && cfg_if.cfg_ch == i) begin
                    m_sh_div[i]  = int'(cfg_if.cfg_div);
                    m_sh_mode[i] = cfg_if.cfg_mode;
                end
                if (stop[i]) begin
                    m_run[i] = 1'b0;
                end else if (start[i]) begin
                    m_run[i] = 1'b1; m_mode[i] = m_sh_mode[i]; m_left[i] = m_sh_div[i] - 1;
                end else if (m_run[i]) begin
                    if (tk) begin
                        if (m_mode[i]) m_run[i] = 1'b0;
                        else begin m_mode[i] = m_sh_mode[i]; m_left[i] = m_sh_div[i] - 1; end
                    end else if (stb) begin
                        m_left[i]--;
                    end
                end
            end
            m_err   = cfg_if.cfg_valid && m_ready && bad;
            m_ready = 1'b1;
            m_pre   = (m_pre + 1) % P;
        end
    end

    always @(negedge sys_clk) begin
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("model_tick[%0d]", i), tick_enable[i], m_tick(i));
            check($sformatf("model_busy[%0d]", i), busy[i], m_run[i]);
        end
        check("model_cfg_err", cfg_if.cfg_err, m_err);
        check("model_cfg_ready", cfg_if.cfg_ready, m_ready);
    end

    task automatic step();
        @(negedge sys_clk);
        start            = '0;
        stop             = '0;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int div, input logic mode);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_div   = DW'(div);
        cfg_if.cfg_mode  = mode;
        step();
    endtask

    task automatic wait_tick(input int ch, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_enable[ch] && n < max);
        if (!tick_enable[ch]) begin
            checks++;
            errors++;
            $display("FAIL wait_tick[%0d]: no tick within %0d cycles", ch, max);
        end
    endtask

    task automatic count_ticks(input int ch, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            if (tick_enable[ch]) cnt++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_mode  = 1'b0;

        repeat (2) @(negedge sys_clk);
        check("rst_busy", busy, 0);
        check("rst_tick", tick_enable, 0);
        check("rst_cfg_err", cfg_if.cfg_err, 0);
        check("rst_cfg_ready", cfg_if.cfg_ready, 0);
        sys_rst_n = 1'b1;
        step();
        step();
        check("cfg_ready_after_rst", cfg_if.cfg_ready, 1);

        // ch0: div 5 continuous
        cfg_write(0, 5, MODE_CONT);
        start = 3'b001;
        wait_tick(0, 64 * P, n);
        check_range("ch0_first_tick", n, 4 * P, 5 * P);
        check("ch0_busy", busy[0], 1);
        wait_tick(0, 64 * P, n);
        check("ch0_period", n, 5 * P);

        // ch1: div 10, rewritten to 3 mid-period
        cfg_write(1, 10, MODE_CONT);
        start = 3'b010;
        repeat (4 * P) step();
        cfg_write(1, 3, MODE_CONT);
        wait_tick(1, 64 * P, n);
        check_range("ch1_old_period_completes", n, 5 * P - 1, 6 * P - 1);
        wait_tick(1, 64 * P, n);
        check("ch1_new_period_a", n, 3 * P);
        wait_tick(1, 64 * P, n);
        check("ch1_new_period_b", n, 3 * P);

        // ch2: one-shot div 4
        cfg_write(2, 4, MODE_ONESHOT);
        start = 3'b100;
        wait_tick(2, 64 * P, n);
        check_range("ch2_oneshot_tick", n, 3 * P, 4 * P);
        step();
        check("ch2_oneshot_busy_falls", busy[2], 0);
        count_ticks(2, 12 * P, cnt);
        check("ch2_oneshot_no_more_ticks", cnt, 0);

        // rejected writes
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = '0;
        step();
        check("err_div0_pulse", cfg_if.cfg_err, 1);
        step();
        check("err_div0_one_cycle", cfg_if.cfg_err, 0);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = DW'(7);
        step();
        check("err_bad_ch_pulse", cfg_if.cfg_err, 1);
        step();
        check("err_bad_ch_one_cycle", cfg_if.cfg_err, 0);
        wait_tick(0, 64 * P, n);
        wait_tick(0, 64 * P, n);
        check("ch0_period_after_rejects", n, 5 * P);

        // div 1 holds tick high (one per strobe)
        cfg_write(2, 1, MODE_CONT);
        start = 3'b100;
        step();
        count_ticks(2, 5 * P, cnt);
        check("ch2_div1_ticks", cnt, 5);

        // start and stop together: stop wins
        start = 3'b001;
        stop  = 3'b001;
        step();
        check("ch0_start_stop_idle", busy[0], 0);
        count_ticks(0, 8 * P, cnt);
        check("ch0_idle_no_ticks", cnt, 0);

        // stop coincident with a tick
        wait_tick(1, 64 * P, n);
        check("ch1_tick_at_stop", tick_enable[1], 1);
        stop = 3'b010;
        step();
        check("ch1_stopped", busy[1], 0);
        count_ticks(1, 6 * P, cnt);
        check("ch1_no_ticks_after_stop", cnt, 0);

        // asynchronous reset mid-count
        check("ch2_running_before_rst", busy[2], 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_tick", tick_enable, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_cfg_err", cfg_if.cfg_err, 0);
        check("async_rst_cfg_ready", cfg_if.cfg_ready, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        start = 3'b001;
        wait_tick(0, 64 * P, n);
        check_range("default_div_after_rst", n, 5 * P, 6 * P);

        // random traffic
        for (int it = 0; it < 3000; it++) begin
            step();
            if (it == 1500) begin
                #2 sys_rst_n = 1'b0;
                step();
                step();
                sys_rst_n = 1'b1;
            end
            if ($urandom_range(7) == 0) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_ch    = 2'($urandom_range(3));
                cfg_if.cfg_div   = DW'($urandom_range(9));
                cfg_if.cfg_mode  = ($urandom_range(3) == 0);
            end
            for (int i = 0; i < NCH; i++) begin
                start[i] = ($urandom_range(15) == 0);
                stop[i]  = ($urandom_range(31) == 0);
            end
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
